// File: rtl/mac_seq_if.sv
// Handshake and index bus between the MAC sequencer and the operand files / MAC datapath.
// master = sequencer side, slave = datapath/consumer side.
interface mac_seq_if #(
  parameter int IDX_W = 2
);
  logic             start;
  logic             abort;
  logic [IDX_W-1:0] row_idx;
  logic [IDX_W-1:0] col_idx;
  logic [IDX_W-1:0] k_idx;
  logic             mac_clear;
  logic             mac_ld;
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_row;
  logic [IDX_W-1:0] res_col;
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, res_ready,
    output row_idx, col_idx, k_idx, mac_clear, mac_ld,
    output res_valid, res_row, res_col, busy, done
  );

  modport slave (
    output start, abort, res_ready,
    input  row_idx, col_idx, k_idx, mac_clear, mac_ld,
    input  res_valid, res_row, res_col, busy, done
  );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences C = A x B over an N x N grid: CLR, N ACC cycles, OUT per element (N+2 cycles at full rate).
// Results wait in OUT under res_valid until res_ready; abort returns to IDLE from any state.
module mac_sequencer #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  mac_seq_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    ACC  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t           state, state_n;
  logic [IDX_W-1:0] row, col, k;
  logic [IDX_W-1:0] row_n, col_n, k_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      k     <= '0;
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
      k     <= k_n;
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    k_n     = k;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = CLR;
          row_n   = '0;
          col_n   = '0;
          k_n     = '0;
        end
      end
      CLR: begin
        state_n = ACC;
        k_n     = '0;
      end
      ACC: begin
        if (k == LAST) begin
          state_n = OUT;
          k_n     = '0;
        end else begin
          k_n = k + ONE;
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          if (row == LAST && col == LAST) begin
            state_n = DONE;
            row_n   = '0;
            col_n   = '0;
          end else if (col == LAST) begin
            state_n = CLR;
            col_n   = '0;
            row_n   = row + ONE;
          end else begin
            state_n = CLR;
            col_n   = col + ONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        row_n   = '0;
        col_n   = '0;
        k_n     = '0;
      end
      default: begin
        state_n = IDLE;
        row_n   = '0;
        col_n   = '0;
        k_n     = '0;
      end
    endcase
    // abort outranks start and the result handshake
    if (bus.abort) begin
      state_n = IDLE;
      row_n   = '0;
      col_n   = '0;
      k_n     = '0;
    end
  end

  assign bus.row_idx   = row;
  assign bus.col_idx   = col;
  assign bus.k_idx     = k;
  assign bus.res_row   = row;
  assign bus.res_col   = col;
  assign bus.mac_clear = (state == CLR);
  assign bus.mac_ld    = (state == ACC);
  assign bus.res_valid = (state == OUT);
  assign bus.busy      = (state == CLR) || (state == ACC) || (state == OUT);
  assign bus.done      = (state == DONE);

  a_sel_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.mac_clear && bus.mac_ld));
  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
    (row <= LAST) && (col <= LAST) && (k <= LAST));

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: cycle table, directed multiplies and randomized multiplies
// checked against a plain matrix-product / row-major-order reference.
module tb_mac_sequencer;
  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   a [N][N];
  int   b [N][N];
  logic [9:0] acc;

  mac_seq_if #(.IDX_W(IDX_W)) bus ();

  mac_sequencer #(.N(N), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand files plus 10-bit accumulate register driven by the sequencer's selects
  always @(posedge clk) begin
    if (bus.mac_clear)
      acc <= 10'd0;
    else if (bus.mac_ld)
      acc <= acc + 10'(a[bus.row_idx][bus.k_idx] * b[bus.k_idx][bus.col_idx]);
  end

  typedef struct {
    bit start;
    bit abort;
    bit ready;
    bit clr;
    bit ld;
    bit vld;
    bit bsy;
    bit dn;
    int row;
    int col;
    int k;
  } vec_t;

  function automatic vec_t mk(bit s, bit ab, bit r, bit c, bit l, bit v, bit bz, bit d,
                              int row, int col, int k);
    vec_t t;
    t.start = s;  t.abort = ab; t.ready = r;
    t.clr = c;    t.ld = l;     t.vld = v;   t.bsy = bz; t.dn = d;
    t.row = row;  t.col = col;  t.k = k;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        case (mode)
          0:       begin a[i][j] = (i == j) ? 1 : 0; b[i][j] = 4 * i + j; end
          1:       begin a[i][j] = 15; b[i][j] = 15; end
          default: begin a[i][j] = $urandom_range(0, 15); b[i][j] = $urandom_range(0, 15); end
        endcase
      end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_valid"}, bus.res_valid, 0);
    check({tag, "_clr"}, bus.mac_clear, 0);
    check({tag, "_ld"}, bus.mac_ld, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_row"}, bus.row_idx, 0);
    check({tag, "_col"}, bus.col_idx, 0);
    check({tag, "_k"}, bus.k_idx, 0);
  endtask

  // mode 0: ready always; 1: 5-cycle stall on element (1,2); 2: random ready + stray starts
  task automatic run_multiply(input int mode, input int abort_elem, input string tag);
    int  exp_c [N][N];
    int  elem, cyc, stalls, clears, lds, busys, hold;
    bit  hs_pending, fin, rdy;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        exp_c[r][c] = 0;
        for (int kk = 0; kk < N; kk++) exp_c[r][c] += a[r][kk] * b[kk][c];
      end
    elem = 0; stalls = 0; clears = 0; lds = 0; busys = 0; hold = 0;
    hs_pending = 0; fin = 0;
    bus.start = 1; bus.res_ready = 1; bus.abort = 0;
    step();
    bus.start = 0;
    cyc = 1;
    while (!fin && cyc < 4000) begin
      clears += int'(bus.mac_clear);
      lds    += int'(bus.mac_ld);
      busys  += int'(bus.busy);
      check({tag, "_clr_ld_excl"}, bus.mac_clear & bus.mac_ld, 0);
      if (hs_pending) begin
        hs_pending = 0;
        if (elem < N * N) begin
          check({tag, "_next_clr"}, bus.mac_clear, 1);
          check({tag, "_next_row"}, bus.row_idx, elem / N);
          check({tag, "_next_col"}, bus.col_idx, elem % N);
        end else begin
          check({tag, "_last_done"}, bus.done, 1);
        end
      end
      if (bus.done) begin
        fin = 1;
        check({tag, "_done_cycle"}, cyc, N * N * (N + 2) + stalls + 1);
        check({tag, "_done_busy"}, bus.busy, 0);
        check({tag, "_done_row"}, bus.row_idx, 0);
        check({tag, "_done_col"}, bus.col_idx, 0);
        check({tag, "_done_k"}, bus.k_idx, 0);
      end
      if (bus.res_valid) begin
        check({tag, "_res_row"}, bus.res_row, elem / N);
        check({tag, "_res_col"}, bus.res_col, elem % N);
        check({tag, "_result"}, int'(acc), exp_c[elem / N][elem % N]);
        check({tag, "_out_ld"}, bus.mac_ld, 0);
        if (elem == abort_elem) begin
          bus.abort = 1; bus.res_ready = 1;
          step();
          bus.abort = 0;
          check_idle({tag, "_after_abort"});
          for (int i = 0; i < 4; i++) begin
            step();
            check({tag, "_no_done"}, bus.done, 0);
            check({tag, "_stay_idle"}, bus.busy, 0);
          end
          return;
        end
        case (mode)
          0: rdy = 1;
          1: begin
            if (elem == N + 2 && hold < 5) begin rdy = 0; hold++; end
            else rdy = 1;
          end
          default: rdy = ($urandom_range(0, 2) != 0);
        endcase
        bus.res_ready = rdy;
        if (rdy) begin elem++; hs_pending = 1; end
        else stalls++;
      end else begin
        bus.res_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      bus.start = (fin || (mode == 2 && bus.busy)) ? 1'($urandom_range(0, 1)) | fin : 1'b0;
      if (!fin) begin
        step();
        cyc++;
      end
    end
    check({tag, "_finished"}, fin, 1);
    if (fin) begin
      step();
      bus.start = 0;
      check({tag, "_start_in_done_busy"}, bus.busy, 0);
      check({tag, "_start_in_done_clr"}, bus.mac_clear, 0);
      step();
      check({tag, "_idle_after_done"}, bus.busy, 0);
    end
    check({tag, "_elements"}, elem, N * N);
    check({tag, "_clears"}, clears, N * N);
    check({tag, "_loads"}, lds, N * N * N);
    check({tag, "_busy_cycles"}, busys, N * N * (N + 2) + stalls);
    if (mode == 1) check({tag, "_stalls"}, stalls, 5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt [13];
    bit   saw_ld;
    vt[0]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1);
    vt[4]  = mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 2);
    vt[5]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 3);
    vt[6]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    vt[8]  = mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0);
    vt[9]  = mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0);
    vt[10] = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[11] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[12] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    n_tests = 0;
    n_fail  = 0;
    bus.start = 0; bus.abort = 0; bus.res_ready = 1;
    fill(0);
    rst_n = 1;
    #1 rst_n = 0;
    #1 check_idle("reset");
    @(negedge clk);
    rst_n = 1;
    step();
    check_idle("post_reset");

    for (int i = 0; i < 13; i++) begin
      bus.start = vt[i].start;
      bus.abort = vt[i].abort;
      bus.res_ready = vt[i].ready;
      step();
      check($sformatf("vec%0d_clr", i), bus.mac_clear, vt[i].clr);
      check($sformatf("vec%0d_ld", i), bus.mac_ld, vt[i].ld);
      check($sformatf("vec%0d_valid", i), bus.res_valid, vt[i].vld);
      check($sformatf("vec%0d_busy", i), bus.busy, vt[i].bsy);
      check($sformatf("vec%0d_done", i), bus.done, vt[i].dn);
      check($sformatf("vec%0d_row", i), bus.row_idx, vt[i].row);
      check($sformatf("vec%0d_col", i), bus.col_idx, vt[i].col);
      check($sformatf("vec%0d_k", i), bus.k_idx, vt[i].k);
    end
    bus.start = 0; bus.abort = 0; bus.res_ready = 1;

    fill(0); run_multiply(0, -1, "identity");
    fill(1); run_multiply(0, -1, "saturate");
    fill(2); run_multiply(1, -1, "backpressure");
    fill(2); run_multiply(0, 2 * N, "abort");

    // asynchronous reset in the middle of an accumulate run
    bus.start = 1; step(); bus.start = 0;
    saw_ld = 0;
    for (int i = 0; i < 10 && !saw_ld; i++) begin
      if (bus.mac_ld) saw_ld = 1;
      else step();
    end
    check("rst_mid_reached_acc", saw_ld, 1);
    step();
    #2 rst_n = 0;
    #1 check_idle("rst_mid_async");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_done", bus.done, 0);
    end

    for (int t = 0; t < 3; t++) begin
      fill(2);
      run_multiply(2, -1, $sformatf("random%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Controller that drives the matrix-multiply MAC datapath for C = A x B, with A and B both N x N matrices of 4-bit elements.
- Generates operand indices row/k/col and the accumulator select lines mac_clear / mac_ld for the 10-bit accumulate mux and register.
- Presents each finished C element with a valid/ready handshake.
- Sits between the top-level start/done control and the operand register files plus MAC datapath.

Parameters:
- N, 4, matrix dimension. Legal range 2..4: 4 x 225 = 900 fits the 10-bit accumulator.
- IDX_W, 2, index width. Must satisfy 2**IDX_W >= N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a full multiply. Sampled only in IDLE.
- abort  input  1  synchronous cancel. Honoured in every state.
- row_idx  output  IDX_W  current C row; A row address.
- col_idx  output  IDX_W  current C column; B column address.
- k_idx  output  IDX_W  inner index; A column and B row address.
- mac_clear  output  1  accumulator clear select.
- mac_ld  output  1  accumulator load select (acc <= acc + product).
- res_valid  output  1  C[res_row][res_col] is available on the accumulator output.
- res_ready  input  1  consumer accepts the result.
- res_row  output  IDX_W  row of the presented result.
- res_col  output  IDX_W  column of the presented result.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All indices = 0.
  - mac_clear, mac_ld, res_valid, busy, done = 0.
  - Reset mid-operation discards all progress; no done is produced.
- States: IDLE, CLR, ACC, OUT, DONE. State register and counters are updated on the rising clk edge. All outputs are decoded from registered state and counters (Moore), so no combinational input-to-output path exists except none.
- IDLE:
  - Outputs idle; mac_clear = mac_ld = 0, so the accumulator holds.
  - start = 1 -> CLR, with row = col = k = 0.
- CLR (1 cycle):
  - mac_clear = 1, busy = 1.
  - Next state ACC, k = 0.
- ACC (exactly N cycles):
  - mac_ld = 1, busy = 1.
  - Each cycle k_idx selects operands A[row][k] and B[k][col]; the datapath accumulates their product at the edge.
  - When k = N-1: go to OUT and reset k to 0. Otherwise k increments.
- OUT:
  - res_valid = 1, busy = 1, mac_clear = mac_ld = 0.
  - res_row / res_col equal row_idx / col_idx and remain stable while res_ready = 0.
  - res_valid stays high until the handshake completes (res_valid & res_ready at an edge).
  - On handshake:
    - If row = N-1 and col = N-1: go to DONE.
    - Else if col = N-1: col = 0, row + 1, go to CLR.
    - Else: col + 1, go to CLR.
  - Elements are produced in row-major order.
- DONE (1 cycle):
  - done = 1, busy = 0, indices return to 0.
  - Next state IDLE.
- Invariants:
  - mac_clear and mac_ld are never both 1.
  - mac_clear / mac_ld are 0 in IDLE, OUT and DONE.
- Latency: N+2 cycles per element when res_ready is held at 1. A full multiply takes N*N*(N+2) busy cycles, then 1 DONE cycle.
- start:
  - Ignored while not in IDLE.
  - start asserted during DONE is also ignored; it must be re-asserted in IDLE.
- abort:
  - abort = 1 at any edge -> IDLE on the next cycle, indices = 0, no done pulse.
  - abort has priority over start and over the res handshake in the same cycle.
- Counters:
  - Only values 0..N-1 are ever reached; no wrap to 2**IDX_W.
  - Index outputs in IDLE are 0.

Test Plan:
1. Reset mid-ACC: drive rst_n low while in ACC -> all outputs 0 immediately; after release, state is IDLE and busy = 0.
2. Full multiply, N=4, res_ready = 1, A = identity, B[i][j] = 4i+j -> exactly 16 res_valid cycles in row-major order, results 0..15.
   - done pulses exactly once, in cycle 97 after start is sampled.
   - mac_clear occurs 16 times and mac_ld occurs 64 times.
3. Saturation, A and B all 15 -> every result is 900 (no 10-bit overflow) and mac_clear never overlaps mac_ld.
4. Backpressure: hold res_ready = 0 for 5 cycles on element (1,2) -> res_valid, res_row = 1, res_col = 2 and the accumulator value stay constant; mac_ld = 0 throughout.
   - Release res_ready -> the next cycle is CLR for element (1,3).
5. Abort and stray start:
   - Assert abort during OUT of element (2,0) together with res_ready = 1 -> next state IDLE, no done, indices 0.
   - A start pulse during busy -> no effect on sequence or counts.
